// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the return-address-stack front end.
package cpu_pkg;

    // Sequencer modes: normal request handling, or draining the stack.
    typedef enum logic [0:0] {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } ras_state_t;

    // Number of entries in the ras instance; the sequencer tracks depth against it.
    localparam int RAS_DEPTH = 8;

    // Instruction address width.
    localparam int ADDR_W = 16;

endpackage

// File: rtl/ras_arb.sv
// Fixed-priority grant among N requesters: index 0 has the highest priority.
// A requester is ready when the arbiter is enabled and nobody above it asks.
module ras_arb #(
    parameter int N = 2
) (
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [N-1:0] ready,
    output logic [N-1:0] gnt
);

    // blocked[i] is set when any requester with a lower index is requesting.
    logic [N-1:0] blocked;

    assign blocked[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < N; gi++) begin : g_chain
            assign blocked[gi] = blocked[gi-1] | req[gi-1];
        end
        for (genvar gi = 0; gi < N; gi++) begin : g_grant
            assign ready[gi] = en & ~blocked[gi];
            assign gnt[gi]   = ready[gi] & req[gi];
        end
    endgenerate

endmodule

// File: rtl/ras_ctrl.sv
// Sequencer/arbiter in front of the return address stack. Issues at most one
// push or pop per cycle, tracks depth and overflowed calls so the predicted
// return target can be qualified, and drains the stack on context switch.
module ras_ctrl
    import cpu_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH,
    parameter int AW    = ADDR_W,
    parameter int LOSTW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dec_call,
    input  logic          dec_ret,
    input  logic [AW-1:0] dec_addr,
    output logic          dec_ready,
    input  logic          irq_entry,
    input  logic          irq_exit,
    input  logic [AW-1:0] irq_pc,
    output logic          irq_ready,
    input  logic          ctx_clear,
    output logic          ras_push,
    output logic          ras_pop,
    output logic [AW-1:0] ras_data,
    input  logic [AW-1:0] ras_top,
    input  logic          ras_err,
    output logic [AW-1:0] pred_addr,
    output logic          pred_valid,
    output logic          busy,
    output logic          fault
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam logic [DW-1:0]    DEPTH_MAX = DW'(DEPTH);
    localparam logic [DW-1:0]    DEPTH_ONE = DW'(1);
    localparam logic [LOSTW-1:0] LOST_MAX  = '1;
    localparam logic [LOSTW-1:0] LOST_ONE  = LOSTW'(1);

    ras_state_t      state_reg, state_next;
    logic [DW-1:0]    depth_reg, depth_next;
    logic [LOSTW-1:0] lost_reg,  lost_next;
    logic             fault_reg;

    // Requests are only taken in RUN, and never in the cycle that starts a
    // clear or while reset is asserted.
    logic       run_en;
    logic [1:0] req;
    logic [1:0] ready;
    logic [1:0] gnt;

    assign run_en = (state_reg == RUN) & ~ctx_clear & ~rst;
    assign req    = {dec_call | dec_ret, irq_entry | irq_exit};

    // Interrupt side sits at index 0 so it always wins over decode.
    ras_arb #(
        .N(2)
    ) u_arb (
        .en   (run_en),
        .req  (req),
        .ready(ready),
        .gnt  (gnt)
    );

    assign irq_ready = ready[0];
    assign dec_ready = ready[1];

    // Decode the granted request into a single operation; pop beats push.
    logic          op_push;
    logic          op_pop;
    logic [AW-1:0] op_addr;

    always_comb begin
        op_pop  = (gnt[0] & irq_exit) | (gnt[1] & dec_ret);
        op_push = (gnt[0] & irq_entry & ~irq_exit) | (gnt[1] & dec_call & ~dec_ret);
        op_addr = gnt[0] ? irq_pc : dec_addr;
    end

    // Next-state and strobe generation; strobes are zero-latency so ras
    // updates on the same edge as depth/lost.
    always_comb begin
        state_next = state_reg;
        depth_next = depth_reg;
        lost_next  = lost_reg;
        ras_push   = 1'b0;
        ras_pop    = 1'b0;
        ras_data   = '0;
        if (!rst) begin
            case (state_reg)
                RUN: begin
                    if (ctx_clear) begin
                        state_next = CLEAR;
                        lost_next  = '0;
                    end else if (op_push) begin
                        if (depth_reg != DEPTH_MAX) begin
                            ras_push   = 1'b1;
                            ras_data   = op_addr;
                            depth_next = depth_reg + DEPTH_ONE;
                        end else if (lost_reg != LOST_MAX) begin
                            // Stack full: remember the call so its return is not
                            // matched against a stale entry.
                            lost_next = lost_reg + LOST_ONE;
                        end
                    end else if (op_pop) begin
                        if (lost_reg != '0) begin
                            lost_next = lost_reg - LOST_ONE;
                        end else if (depth_reg != '0) begin
                            ras_pop    = 1'b1;
                            depth_next = depth_reg - DEPTH_ONE;
                        end
                    end
                end
                CLEAR: begin
                    if (depth_reg != '0) begin
                        ras_pop    = 1'b1;
                        depth_next = depth_reg - DEPTH_ONE;
                    end else begin
                        state_next = RUN;
                    end
                end
                default: state_next = RUN;
            endcase
        end
    end

    // State registers; fault is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= RUN;
            depth_reg <= '0;
            lost_reg  <= '0;
            fault_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            depth_reg <= depth_next;
            lost_reg  <= lost_next;
            fault_reg <= fault_reg | ras_err;
        end
    end

    assign pred_addr  = ras_top;
    assign pred_valid = (depth_reg != '0) && (lost_reg == '0) && (state_reg == RUN);
    assign busy       = (state_reg == CLEAR);
    assign fault      = fault_reg;

endmodule

// File: tb/tb_ras_ctrl.sv
// Bench for ras_ctrl: a behavioural return address stack stands in for ras,
// and a queue-based reference model predicts every output each cycle.
module tb_ras_ctrl;
    import cpu_pkg::*;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst, dec_call, dec_ret, irq_entry, irq_exit, ctx_clear, ras_err;
    logic [AW-1:0] dec_addr, irq_pc, ras_data, ras_top, pred_addr;
    logic          dec_ready, irq_ready, ras_push, ras_pop, pred_valid, busy, fault;

    always #5 clk = ~clk;

    ras_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .dec_call  (dec_call),
        .dec_ret   (dec_ret),
        .dec_addr  (dec_addr),
        .dec_ready (dec_ready),
        .irq_entry (irq_entry),
        .irq_exit  (irq_exit),
        .irq_pc    (irq_pc),
        .irq_ready (irq_ready),
        .ctx_clear (ctx_clear),
        .ras_push  (ras_push),
        .ras_pop   (ras_pop),
        .ras_data  (ras_data),
        .ras_top   (ras_top),
        .ras_err   (ras_err),
        .pred_addr (pred_addr),
        .pred_valid(pred_valid),
        .busy      (busy),
        .fault     (fault)
    );

    // Stand-in for the ras block, driven purely by the DUT strobes.
    logic [AW-1:0] stk [8];
    int            stk_cnt = 0;

    always @(posedge clk) begin
        if (rst) begin
            stk_cnt <= 0;
        end else if (ras_push && stk_cnt < 8) begin
            stk[stk_cnt] <= ras_data;
            stk_cnt      <= stk_cnt + 1;
        end else if (ras_pop && stk_cnt > 0) begin
            stk_cnt <= stk_cnt - 1;
        end
    end

    assign ras_top = (stk_cnt > 0) ? stk[stk_cnt-1] : '0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: mq is the set of real stack entries, m_lost counts
    // overflowed calls, m_clr counts remaining clear cycles (0 = running).
    logic [AW-1:0] mq[$];
    int            m_lost = 0;
    int            m_clr  = 0;
    logic          m_fault = 1'b0;

    int            ob_push, ob_pop, ob_busy, ob_dec_acc;
    logic          ob_irq_rdy, ob_dec_rdy;
    logic [AW-1:0] ob_data;

    // One clock cycle: drive inputs, check outputs mid-cycle, advance model.
    task automatic cyc(input logic r, input logic ctx, input logic ie, input logic ix,
                       input logic [AW-1:0] pc, input logic dc, input logic dr,
                       input logic [AW-1:0] da, input logic er);
        logic          run, en, e_irq_rdy, e_dec_rdy, e_push, e_pop, push_req, pop_req;
        logic          e_busy, e_pv, e_fault;
        logic [AW-1:0] e_data, addr, e_top;
        int            e_depth, e_lost;
        rst = r; ctx_clear = ctx; irq_entry = ie; irq_exit = ix; irq_pc = pc;
        dec_call = dc; dec_ret = dr; dec_addr = da; ras_err = er;
        #4;
        run       = (m_clr == 0);
        en        = run && !ctx && !r;
        e_irq_rdy = en;
        e_dec_rdy = en && !(ie || ix);
        push_req  = 1'b0; pop_req = 1'b0; addr = '0;
        if (en && (ie || ix)) begin
            pop_req = ix; push_req = ie && !ix; addr = pc;
        end else if (e_dec_rdy && (dc || dr)) begin
            pop_req = dr; push_req = dc && !dr; addr = da;
        end
        e_busy  = !run;
        e_pv    = (mq.size() > 0) && (m_lost == 0) && run;
        e_fault = m_fault;
        e_top   = (mq.size() > 0) ? mq[$] : '0;
        e_depth = mq.size();
        e_lost  = m_lost;
        e_push = 1'b0; e_pop = 1'b0; e_data = '0;
        if (r) begin
            mq.delete(); m_lost = 0; m_clr = 0; m_fault = 1'b0;
        end else begin
            if (!run) begin
                if (mq.size() > 0) begin e_pop = 1'b1; void'(mq.pop_back()); end
                m_clr--;
            end else if (ctx) begin
                m_clr = mq.size() + 1; m_lost = 0;
            end else if (push_req) begin
                if (mq.size() < 8) begin
                    e_push = 1'b1; e_data = addr; mq.push_back(addr);
                end else if (m_lost < 255) begin
                    m_lost++;
                end
            end else if (pop_req) begin
                if (m_lost > 0) m_lost--;
                else if (mq.size() > 0) begin e_pop = 1'b1; void'(mq.pop_back()); end
            end
            if (er) m_fault = 1'b1;
        end
        check_eq("ctl{irdy,drdy,push,pop,busy,pv,fault}",
                 32'({irq_ready, dec_ready, ras_push, ras_pop, busy, pred_valid, fault}),
                 32'({e_irq_rdy, e_dec_rdy, e_push, e_pop, e_busy, e_pv, e_fault}));
        check_eq("ras_data", 32'(ras_data), 32'(e_data));
        check_eq("pred_addr", 32'(pred_addr), 32'(e_top));
        check_eq("depth", 32'(dut.depth_reg), 32'(e_depth));
        check_eq("lost", 32'(dut.lost_reg), 32'(e_lost));
        ob_push    += int'(ras_push);
        ob_pop     += int'(ras_pop);
        ob_busy    += int'(busy);
        ob_dec_acc += int'(dec_ready && (dc || dr));
        ob_irq_rdy = irq_ready;
        ob_dec_rdy = dec_ready;
        ob_data    = ras_data;
        @(posedge clk);
        #1;
    endtask

    task automatic t_idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    endtask
    task automatic t_call(input logic [AW-1:0] a);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, a, 1'b0);
    endtask
    task automatic t_ret();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, '0, 1'b0);
    endtask
    task automatic t_rst();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    endtask
    task automatic clr_obs();
        ob_push = 0; ob_pop = 0; ob_busy = 0; ob_dec_acc = 0;
    endtask

    initial begin
        rst = 1'b1; ctx_clear = 1'b0; irq_entry = 1'b0; irq_exit = 1'b0; irq_pc = '0;
        dec_call = 1'b0; dec_ret = 1'b0; dec_addr = '0; ras_err = 1'b0;
        clr_obs();
        repeat (2) @(posedge clk);
        #1;
        t_rst();
        t_idle();
        check_eq("reset_busy", 32'(busy), 32'(0));
        check_eq("reset_pv", 32'(pred_valid), 32'(0));

        // Push three, pop three
        t_call(16'h0100); t_call(16'h0200); t_call(16'h0300);
        check_eq("t1_top0300", 32'(pred_addr), 32'h0300);
        t_ret();
        check_eq("t1_top0200", 32'(pred_addr), 32'h0200);
        t_ret();
        check_eq("t1_top0100", 32'(pred_addr), 32'h0100);
        t_ret();
        check_eq("t1_pv_low", 32'(pred_valid), 32'(0));
        check_eq("t1_depth0", 32'(dut.depth_reg), 32'(0));

        // Underflow
        clr_obs();
        t_ret();
        check_eq("t5_no_pop", 32'(ob_pop), 32'(0));
        check_eq("t5_fault", 32'(fault), 32'(0));
        check_eq("t5_depth0", 32'(dut.depth_reg), 32'(0));

        // Overflow
        clr_obs();
        for (int i = 0; i < 10; i++) t_call(16'h1000 + 16'(i));
        check_eq("t2_pushes", 32'(ob_push), 32'(8));
        check_eq("t2_lost2", 32'(dut.lost_reg), 32'(2));
        check_eq("t2_pv_low", 32'(pred_valid), 32'(0));
        clr_obs();
        t_ret(); t_ret();
        check_eq("t2_no_pop", 32'(ob_pop), 32'(0));
        check_eq("t2_pv_high", 32'(pred_valid), 32'(1));
        check_eq("t2_top1007", 32'(pred_addr), 32'h1007);

        // Lost counter saturates
        for (int i = 0; i < 260; i++) t_call(16'h2000);
        check_eq("lost_sat", 32'(dut.lost_reg), 32'(255));
        cyc(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        repeat (9) t_idle();

        // Arbitration
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h4000, 1'b1, 1'b0, 16'h0500, 1'b0);
        check_eq("t3_irq_rdy", 32'(ob_irq_rdy), 32'(1));
        check_eq("t3_dec_rdy", 32'(ob_dec_rdy), 32'(0));
        check_eq("t3_data4000", 32'(ob_data), 32'h4000);
        t_call(16'h0500);
        check_eq("t3_data0500", 32'(ob_data), 32'h0500);

        // Clear from depth 5, with decode requests presented throughout
        t_call(16'h0600); t_call(16'h0700); t_call(16'h0800);
        clr_obs();
        cyc(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, 16'h0900, 1'b0);
        repeat (6) cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 16'h0900, 1'b0);
        check_eq("t4_pops", 32'(ob_pop), 32'(5));
        check_eq("t4_busy", 32'(ob_busy), 32'(6));
        check_eq("t4_refused", 32'(ob_dec_acc), 32'(0));
        check_eq("t4_pv", 32'(pred_valid), 32'(0));
        check_eq("t4_rdy", 32'({irq_ready, dec_ready}), 32'(3));

        // Reset on the second clear cycle
        t_call(16'h0a00); t_call(16'h0b00); t_call(16'h0c00);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        t_idle();
        t_rst();
        rst = 1'b0;
        #1;
        check_eq("t6_outs{irdy,drdy,push,pop,busy,pv,fault}",
                 32'({irq_ready, dec_ready, ras_push, ras_pop, busy, pred_valid, fault}),
                 32'(7'b1100000));
        check_eq("t6_depth0", 32'(dut.depth_reg), 32'(0));

        // Fault is sticky until reset
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        t_idle(); t_idle();
        check_eq("fault_sticky", 32'(fault), 32'(1));
        t_rst();
        check_eq("fault_cleared", 32'(fault), 32'(0));

        // Randomized traffic with call-heavy and return-heavy phases
        for (int i = 0; i < 3000; i++) begin
            logic          r, ctx, ie, ix, dc, dr, er;
            logic [AW-1:0] pc, da;
            int            call_w;
            call_w = ((i / 300) % 2 == 0) ? 70 : 25;
            r   = ($urandom_range(0, 199) == 0);
            ctx = ($urandom_range(0, 59) == 0);
            er  = ($urandom_range(0, 299) == 0);
            ie  = ($urandom_range(0, 5) == 0);
            ix  = ($urandom_range(0, 5) == 0);
            dc  = ($urandom_range(0, 99) < call_w);
            dr  = ($urandom_range(0, 99) < (95 - call_w));
            pc  = AW'($urandom);
            da  = AW'($urandom);
            cyc(r, ctx, ie, ix, pc, dc, dr, da, er);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ras_ctrl.md
# ras_ctrl

Sequencer and arbiter in front of the 8-entry return address stack (`ras`). It takes call/return requests from the decode stage and entry/exit requests from the interrupt unit and issues at most one push or pop to `ras` per cycle. It tracks stack depth and overflowed calls so it can qualify return-target predictions. It also runs a multi-cycle clear sequence on context switch.

## Interface
- `DEPTH`, 8: number of `ras` entries; must match the `ras` instance.
- `AW`, 16: address width.
- `LOSTW`, 8: width of the overflow (lost-entry) counter.

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset. The `ras` instance's `rst_n` is driven from `~rst` at the top level, so both blocks reset together.
- `dec_call`  in  1  decode requests a push of `dec_addr`.
- `dec_ret`  in  1  decode requests a pop.
- `dec_addr`  in  AW  return address for a call.
- `dec_ready`  out  1  the decode request is accepted this cycle.
- `irq_entry`  in  1  interrupt entry; push `irq_pc`.
- `irq_exit`  in  1  interrupt return; pop.
- `irq_pc`  in  AW  interrupted PC.
- `irq_ready`  out  1  the interrupt request is accepted this cycle.
- `ctx_clear`  in  1  single-cycle pulse that empties the stack.
- `ras_push`, `ras_pop`  out  1  command strobes to `ras`.
- `ras_data`  out  AW  push data to `ras`.
- `ras_top`  in  AW  `top_of_stack` from `ras`.
- `ras_err`  in  1  `err` from `ras`.
- `pred_addr`  out  AW  predicted return target (= `ras_top`).
- `pred_valid`  out  1  `pred_addr` is trustworthy.
- `busy`  out  1  clear sequence in progress.
- `fault`  out  1  sticky flag: `ras` signalled an error.

## Operation
- State machine states: RUN and CLEAR. Reset state is RUN.
- Registers: `depth` (0..DEPTH), `lost` (0..2^LOSTW−1), `fault`. All reset to 0.

RUN state:
- The irq side has priority over decode.
- `irq_ready` = 1 whenever RUN and `ctx_clear` = 0.
- `dec_ready` = 1 only when RUN, `ctx_clear` = 0, and no irq request is present.
- If a requester asserts both push and pop in the same cycle, the pop (return) wins and the push is dropped; the requester must re-present it.
- Accepted push:
  - If `depth` < DEPTH: assert `ras_push`, drive `ras_data` with the address, and increment `depth`.
  - If `depth` == DEPTH: no `ras` command is issued; `lost` increments, saturating at its maximum value.
- Accepted pop:
  - If `lost` > 0: no `ras` command is issued; `lost` decrements.
  - Else if `depth` > 0: assert `ras_pop` and decrement `depth`.
  - Else (underflow): no command is issued and `depth` is unchanged.
- `pred_valid` = (`depth` > 0) && (`lost` == 0) && RUN.

CLEAR state:
- Entered when `ctx_clear` is sampled in RUN. Any request presented in that cycle is refused.
- While `depth` > 0: assert `ras_pop` every cycle and decrement `depth`.
- `lost` is cleared on entry.
- Return to RUN in the cycle after `depth` reaches 0.
- If `ctx_clear` is sampled while `depth` == 0, CLEAR lasts exactly one cycle.
- `busy` = 1, and both ready outputs = 0, throughout CLEAR.
- `ctx_clear` asserted during CLEAR is ignored.

Fault handling:
- `ras_err` = 1 sets `fault`. Only `rst` clears it.
- With correct depth tracking, `ras_err` never fires; `fault` exists for verification and debug.

Output rules:
- `ras_push` and `ras_pop` are never both 1 in the same cycle.
- When neither strobe is active, `ras_data` = 0.

## Timing
- Strobes are combinational from the accepted request and the current state, giving zero-cycle issue. `ras` updates on the next edge.
- `depth`, `lost` and the state update on the same edge as `ras`.
- `pred_addr`/`pred_valid` reflect the stack the cycle after a push or pop.
- CLEAR takes `depth`+1 cycles from the `ctx_clear` edge until the ready outputs return to 1.
- `rst` mid-CLEAR: next cycle is RUN with `depth` = 0; `ras` is reset concurrently.
- `rst` while a request is presented: the request is not accepted.

## Structure
- Shared package `cpu_pkg`:
  - `ras_state_t` enum {RUN, CLEAR}.
  - `RAS_DEPTH` = 8, matching the `ras` parameterisation.
  - `ADDR_W` = 16.
- Single module; `ras` is instantiated by the parent, not inside this block.
- An optional sub-module `ras_arb` (fixed-priority two-requester grant) is natural but not required.

## Test plan
1. Push and pop: `dec_call` three times with 0x0100, 0x0200, 0x0300, then `dec_ret` three times.
   - Required: `pred_addr` reads 0x0300, then 0x0200, then 0x0100.
   - Required: `pred_valid` drops after the third pop, and `depth` = 0.
2. Overflow: ten calls with 0x1000..0x1009.
   - Required: `ras_push` on the first 8 only; `lost` = 2 and `pred_valid` = 0.
   - Then two returns: no `ras_pop` issued, and `pred_valid` = 1 with `pred_addr` = 0x1007.
3. Arbitration: `irq_entry` (0x4000) and `dec_call` (0x0500) in the same cycle.
   - Required: `irq_ready` = 1 and `dec_ready` = 0, and 0x4000 is pushed.
   - 0x0500 is pushed the next cycle.
4. Clear: reach `depth` = 5, then pulse `ctx_clear`.
   - Required: `ras_pop` for 5 consecutive cycles and `busy` = 1 for 6 cycles.
   - Required: requests refused throughout, then `pred_valid` = 0 and ready outputs = 1.
5. Underflow: `dec_ret` at `depth` = 0.
   - Required: no `ras_pop`, `fault` = 0, `depth` stays 0.
6. Reset mid-clear: assert `rst` on the 2nd CLEAR cycle.
   - Required: next cycle RUN, `depth` = 0, all outputs at reset values, `fault` = 0.
